sprite_rom_arbiter: RTL



---
 rtl/sprite_rom_arbiter_if.sv | 36 +++
 rtl/sprite_rom_arbiter.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/sprite_rom_arbiter_if.sv
// Bus between the sprite draw requesters, the shared palette-index ROM and sprite_rom_arbiter.
// req_lock exists only when SPRITE_ARB_BURST_EN is defined.
`timescale 1ns/1ps
interface sprite_rom_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 12,
   parameter int DATA_W  = 9
);
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ-1:0]        req_ready;
   logic [ADDR_W-1:0]         rom_address;
   logic [DATA_W-1:0]         rom_q;
   logic [NUM_REQ-1:0]        rsp_valid;
   logic [DATA_W-1:0]         rsp_data;
   logic                      busy;
`ifdef SPRITE_ARB_BURST_EN
   logic [NUM_REQ-1:0]        req_lock;
`endif

   modport slave (
      input  req_valid, req_addr, rom_q,
`ifdef SPRITE_ARB_BURST_EN
      input  req_lock,
`endif
      output req_ready, rom_address, rsp_valid, rsp_data, busy
   );

   modport master (
      output req_valid, req_addr, rom_q,
`ifdef SPRITE_ARB_BURST_EN
      output req_lock,
`endif
      input  req_ready, rom_address, rsp_valid, rsp_data, busy
   );
endinterface

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one single-port sprite ROM; a tag pipeline routes each rom_q word back
// to its requester. Define SPRITE_ARB_BURST_EN to add req_lock burst ownership.
`timescale 1ns/1ps
module sprite_rom_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 12,
   parameter int DATA_W  = 9,
   parameter int ROM_LAT = 1
) (
   input logic                 vga_clk,
   input logic                 Reset,
   sprite_rom_arbiter_if.slave bus
);
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

   function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
      onehot      = '0;
      onehot[idx] = 1'b1;
   endfunction

   function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
      next_idx = (idx == LAST_IDX) ? '0 : idx + 1'b1;
   endfunction

   logic [IDX_W-1:0]   r_ptr;
   logic [ADDR_W-1:0]  r_rom_address;
   logic [ROM_LAT-1:0] r_tag_vld_p;
   logic [IDX_W-1:0]   r_tag_id_p [ROM_LAT];
   logic [NUM_REQ-1:0] r_rsp_valid;
   logic [DATA_W-1:0]  r_rsp_data;

   logic [NUM_REQ-1:0] w_elig;
   logic               w_found;
   logic [IDX_W-1:0]   w_grant_idx;
   logic [IDX_W:0]     w_sum;
   logic               w_accept;
   logic [ADDR_W-1:0]  w_grant_addr;

`ifdef SPRITE_ARB_BURST_EN
   typedef enum logic {S_IDLE, S_LOCKED} state_t;
   state_t           r_state;
   logic [IDX_W-1:0] r_owner;
   logic             r_idle_cnt;
   logic             w_timeout;

   // While locked, only the owner may compete.
   always_comb begin
      w_elig = bus.req_valid;
      if (r_state == S_LOCKED) w_elig = bus.req_valid & onehot(r_owner);
   end

   assign w_timeout = (r_state == S_LOCKED) && !bus.req_valid[r_owner] && r_idle_cnt;

   always_ff @(posedge vga_clk) begin
      if (Reset) begin
         r_state    <= S_IDLE;
         r_owner    <= '0;
         r_idle_cnt <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_idle_cnt <= 1'b0;
               if (w_accept && bus.req_lock[w_grant_idx]) begin
                  r_state <= S_LOCKED;
                  r_owner <= w_grant_idx;
               end
            end
            S_LOCKED: begin
               if (w_accept) begin
                  r_idle_cnt <= 1'b0;
                  if (!bus.req_lock[r_owner]) r_state <= S_IDLE;
               end else if (!bus.req_valid[r_owner]) begin
                  if (r_idle_cnt) begin
                     r_state    <= S_IDLE;
                     r_idle_cnt <= 1'b0;
                  end else begin
                     r_idle_cnt <= 1'b1;
                  end
               end else begin
                  r_idle_cnt <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
`else
   assign w_elig = bus.req_valid;
`endif

   // Search from r_ptr, wrapping explicitly so non-power-of-two NUM_REQ works.
   always_comb begin
      w_found     = 1'b0;
      w_grant_idx = '0;
      w_sum       = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_sum = {1'b0, r_ptr} + (IDX_W+1)'(k);
         if (w_sum >= (IDX_W+1)'(NUM_REQ)) w_sum = w_sum - (IDX_W+1)'(NUM_REQ);
         if (!w_found && w_elig[w_sum[IDX_W-1:0]]) begin
            w_found     = 1'b1;
            w_grant_idx = w_sum[IDX_W-1:0];
         end
      end
   end

   assign w_accept      = w_found && !Reset;
   assign w_grant_addr  = bus.req_addr[w_grant_idx*ADDR_W +: ADDR_W];
   assign bus.req_ready = w_accept ? onehot(w_grant_idx) : '0;

   // p0: issue address and tag; last tag stage: capture rom_q and strobe the owner
   always_ff @(posedge vga_clk) begin
      if (Reset) begin
         r_ptr         <= '0;
         r_rom_address <= '0;
         r_tag_vld_p   <= '0;
         r_rsp_valid   <= '0;
         r_rsp_data    <= '0;
      end else begin
         if (w_accept) begin
            r_rom_address <= w_grant_addr;
            r_ptr         <= next_idx(w_grant_idx);
         end
`ifdef SPRITE_ARB_BURST_EN
         else if (w_timeout) r_ptr <= next_idx(r_owner);
`endif
         r_tag_vld_p[0] <= w_accept;
         for (int k = 1; k < ROM_LAT; k++) r_tag_vld_p[k] <= r_tag_vld_p[k-1];
         r_rsp_valid <= r_tag_vld_p[ROM_LAT-1] ? onehot(r_tag_id_p[ROM_LAT-1]) : '0;
         if (r_tag_vld_p[ROM_LAT-1]) r_rsp_data <= bus.rom_q;
      end
   end

   always_ff @(posedge vga_clk) begin
      r_tag_id_p[0] <= w_grant_idx;
      for (int k = 1; k < ROM_LAT; k++) r_tag_id_p[k] <= r_tag_id_p[k-1];
   end

   assign bus.rom_address = r_rom_address;
   assign bus.rsp_valid   = r_rsp_valid;
   assign bus.rsp_data    = r_rsp_data;
   assign bus.busy        = |r_tag_vld_p;
endmodule
